uart_rx_word_asm: RTL and testbench

Parametrised receive-side word assembler for the UART path. It takes the per-byte strobe and data from the byte receiver (`recevier`) and packs a configurable number of bytes into one wide word. The finished word is presented on a valid/ready output register, and assembly of the next word continues while that register waits. It replaces the fixed 128-bit, handshake-less collector with defined byte order, error and overrun reporting, and an optional inter-byte timeout.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_word_outreg.sv | 28 ++
 rtl/uart_rx_word_asm.sv | 107 ++++++++++
 tb/tb_uart_rx_word_asm.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: assembler FSM state,
// default byte width and the counter width rule.
package uart_pkg;
  localparam int BYTE_W_DEF = 8;

  typedef enum logic {IDLE, COLLECT} asm_state_t;

  // Counter wide enough to hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/uart_word_outreg.sv
// Single-entry valid/ready output register. busy flags a held word that is
// not draining this cycle, i.e. a new load would overwrite it.
module uart_word_outreg #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         word_ready,
  output logic         word_valid,
  output logic [W-1:0] word_data,
  output logic         busy
);
  assign busy = word_valid && !word_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_valid <= 1'b0;
      word_data  <= '0;
    end else if (load) begin
      word_valid <= 1'b1;
      word_data  <= load_data;
    end else if (word_ready) begin
      word_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_rx_word_asm.sv
// Packs received UART bytes into WORD_BYTES-wide words behind a valid/ready
// register. Define UART_RX_WORD_TIMEOUT_EN to add the inter-byte timeout.
module uart_rx_word_asm
  import uart_pkg::*;
#(
  parameter int BYTE_W      = BYTE_W_DEF,
  parameter int WORD_BYTES  = 16,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en_rx,
  input  logic                         byte_valid,
  input  logic [BYTE_W-1:0]            byte_data,
  input  logic                         byte_err,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic [BYTE_W*WORD_BYTES-1:0] word_data,
  output logic                         frame_err,
  output logic                         overrun,
  output logic                         timeout
);
  localparam int W     = BYTE_W * WORD_BYTES;
  localparam int CNT_W = cnt_w(WORD_BYTES);

  asm_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     asm_reg;
  logic [W-1:0]     shifted;
  logic             acc, last, busy, load, to_hit;

  assign acc     = en_rx && byte_valid && !byte_err;
  assign shifted = MSB_FIRST ? {asm_reg[W-BYTE_W-1:0], byte_data}
                             : {byte_data, asm_reg[W-1:BYTE_W]};
  assign last    = acc && (state == COLLECT) && (cnt == CNT_W'(WORD_BYTES - 1));
  assign load    = last && !busy;

`ifdef UART_RX_WORD_TIMEOUT_EN
  localparam int IDLE_W = cnt_w(TIMEOUT_CYC);
  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout_q;

  assign to_hit  = en_rx && !byte_err && !byte_valid && (state == COLLECT) &&
                   (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));
  assign timeout = timeout_q;

  // Counts idle clocks inside a word; any byte, error or exit restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_hit;
      if (!en_rx || byte_valid || byte_err || state == IDLE || to_hit)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      asm_reg   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (!en_rx || byte_err || to_hit) begin
        state     <= IDLE;
        cnt       <= '0;
        asm_reg   <= '0;
        frame_err <= en_rx && byte_err;
      end else if (byte_valid) begin
        if (last) begin
          // Word leaves the assembler whether or not the output could take it.
          state   <= IDLE;
          cnt     <= '0;
          asm_reg <= '0;
          overrun <= busy;
        end else begin
          state   <= COLLECT;
          cnt     <= cnt + 1'b1;
          asm_reg <= shifted;
        end
      end
    end
  end

  uart_word_outreg #(.W(W)) u_outreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_data  (shifted),
    .word_ready (word_ready),
    .word_valid (word_valid),
    .word_data  (word_data),
    .busy       (busy)
  );
endmodule

// File: tb/tb_uart_rx_word_asm.sv
// Directed bench: default 16-byte MSB-first instance plus 4-byte MSB- and
// LSB-first instances sharing one byte stream.
module tb_uart_rx_word_asm;
  logic         clk = 1'b0;
  logic         rst_n, en_rx, byte_valid, byte_err, word_ready;
  logic [7:0]   byte_data;

  logic         wv16, fe16, ov16, to16;
  logic [127:0] wd16;
  logic         wv4, fe4, ov4, to4;
  logic [31:0]  wd4;
  logic         wvl, fel, ovl, tol;
  logic [31:0]  wdl;

  int n_chk = 0, n_fail = 0;
  int fe4_n = 0, ov4_n = 0, to4_n = 0, fe16_n = 0, ov16_n = 0;

  always #5 clk = ~clk;

  uart_rx_word_asm u_dut16 (
    .clk(clk), .rst_n(rst_n), .en_rx(en_rx), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_err(byte_err), .word_valid(wv16),
    .word_ready(word_ready), .word_data(wd16), .frame_err(fe16),
    .overrun(ov16), .timeout(to16));

  uart_rx_word_asm #(.WORD_BYTES(4), .MSB_FIRST(1'b1), .TIMEOUT_CYC(10)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en_rx(en_rx), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_err(byte_err), .word_valid(wv4),
    .word_ready(word_ready), .word_data(wd4), .frame_err(fe4),
    .overrun(ov4), .timeout(to4));

  uart_rx_word_asm #(.WORD_BYTES(4), .MSB_FIRST(1'b0), .TIMEOUT_CYC(10)) u_dutl (
    .clk(clk), .rst_n(rst_n), .en_rx(en_rx), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_err(byte_err), .word_valid(wvl),
    .word_ready(word_ready), .word_data(wdl), .frame_err(fel),
    .overrun(ovl), .timeout(tol));

  // Pulse tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (fe4)  fe4_n++;
    if (ov4)  ov4_n++;
    if (to4)  to4_n++;
    if (fe16) fe16_n++;
    if (ov16) ov16_n++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1; byte_data = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic flush();
    en_rx = 1'b0; tick(); en_rx = 1'b1;
  endtask

  int s_fe, s_ov, s_to, s_ov16, s_fe16;

  initial begin
    rst_n = 1'b0; en_rx = 1'b0; byte_valid = 1'b0; byte_err = 1'b0;
    word_ready = 1'b0; byte_data = 8'h00;
    #12;
    chk("rst_valid", {125'd0, wv16, wv4, wvl}, 128'd0);
    chk("rst_data16", wd16, 128'd0);
    chk("rst_pulses", {124'd0, fe16, ov16, to16, fe4 | ov4 | to4}, 128'd0);
    rst_n = 1'b1; tick();

    // 16 bytes back to back, consumer always ready
    en_rx = 1'b1; word_ready = 1'b1;
    s_fe16 = fe16_n; s_ov16 = ov16_n;
    for (int i = 0; i < 16; i++) begin
      byte_valid = 1'b1; byte_data = 8'(i); tick();
    end
    byte_valid = 1'b0;
    chk("w16_valid", {127'd0, wv16}, 128'd1);
    chk("w16_data", wd16, 128'h000102030405060708090A0B0C0D0E0F);
    chk("w4_last", {96'd0, wd4}, 128'h0C0D0E0F);
    chk("wl_last", {96'd0, wdl}, 128'h0F0E0D0C);
    tick();
    chk("w16_drained", {127'd0, wv16}, 128'd0);
    chk("w16_no_err", 128'(fe16_n - s_fe16 + ov16_n - s_ov16), 128'd0);

    // byte order, 4-byte words
    flush();
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    chk("lsbf_data", {96'd0, wdl}, 128'hDDCCBBAA);
    chk("msbf_data", {96'd0, wd4}, 128'hAABBCCDD);

    // overrun: consumer stalled across two words
    tick(); flush(); word_ready = 1'b0; s_ov = ov4_n;
    for (int i = 0; i < 8; i++) begin
      send(8'h21 + 8'(i));
      if (i == 3) chk("ovr_first_valid", {127'd0, wv4}, 128'd1);
    end
    chk("ovr_pulse", {127'd0, ov4}, 128'd1);
    chk("ovr_held", {96'd0, wd4}, 128'h21222324);
    chk("ovr_cnt", 128'(u_dut4.cnt), 128'd0);
    tick();
    chk("ovr_once", 128'(ov4_n - s_ov), 128'd1);
    word_ready = 1'b1; tick();
    chk("ovr_drain", {127'd0, wv4}, 128'd0);

    // framing error mid-word, error beats a simultaneous byte
    flush(); s_fe = fe4_n;
    send(8'h01); send(8'h02); send(8'h03);
    byte_err = 1'b1; byte_valid = 1'b1; byte_data = 8'hEE; tick();
    byte_err = 1'b0; byte_valid = 1'b0;
    chk("fe_pulse", {127'd0, fe4}, 128'd1);
    send(8'h11); send(8'h12); send(8'h13);
    chk("fe_partial", {127'd0, wv4}, 128'd0);
    send(8'h14);
    chk("fe_word", {96'd0, wd4}, 128'h11121314);
    chk("fe_once", 128'(fe4_n - s_fe), 128'd1);

    // inter-byte timeout
    tick(); flush(); s_to = to4_n;
    send(8'h41); send(8'h42);
    repeat (10) tick();
    tick();
`ifdef UART_RX_WORD_TIMEOUT_EN
    chk("to_pulses", 128'(to4_n - s_to), 128'd1);
`else
    chk("to_pulses", 128'(to4_n - s_to), 128'd0);
`endif
    send(8'h31); send(8'h32); send(8'h33); send(8'h34);
`ifdef UART_RX_WORD_TIMEOUT_EN
    chk("to_clean", {95'd0, wv4, wd4}, {95'd0, 1'b1, 32'h31323334});
`else
    chk("to_clean", {127'd0, wv4}, 128'd0);
`endif

    // asynchronous reset mid-word
    tick(); flush();
    send(8'h61); send(8'h62);
    #2 rst_n = 1'b0; #1;
    chk("arst_mid_cnt", 128'(u_dut4.cnt), 128'd0);
    chk("arst_mid_out", {126'd0, wv4, wv16}, 128'd0);
    @(negedge clk); rst_n = 1'b1; tick();

    // asynchronous reset with a word pending
    word_ready = 1'b0;
    send(8'h71); send(8'h72); send(8'h73); send(8'h74);
    chk("pend_valid", {127'd0, wv4}, 128'd1);
    #2 rst_n = 1'b0; #1;
    chk("arst_pend", {95'd0, wv4, wd4}, 128'd0);
    @(negedge clk); rst_n = 1'b1; tick();
    word_ready = 1'b1;
    send(8'h51); send(8'h52); send(8'h53); send(8'h54);
    chk("post_rst_word", {95'd0, wv4, wd4}, {95'd0, 1'b1, 32'h51525354});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
